// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester (fetch/data) arbiter and waveform sequencer for the external SRAM
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be_n,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_ack,
    output logic [31:0]       data_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       own_data;

    // Byte-offset bits and address bits beyond the SRAM are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                data_addr[31:ADDR_W+2], data_addr[1:0]};

    assign stall = (if_req & ~if_ack) | (data_req & ~data_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            own_data   <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= 32'd0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            if_ack     <= 1'b0;
            data_ack   <= 1'b0;
            if_rdata   <= 32'd0;
            data_rdata <= 32'd0;
        end else begin
            if_ack   <= 1'b0;
            data_ack <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= WAIT_LD;
                    if (data_req) begin
                        own_data  <= 1'b1;
                        sram_addr <= data_addr[ADDR_W+1:2];
                        sram_be_n <= data_be_n;
                        sram_ce_n <= 1'b0;
                        if (data_we) begin
                            state      <= WR_SETUP;
                            sram_dq_o  <= data_wdata;
                            sram_dq_oe <= 1'b1;
                        end else begin
                            state     <= RD;
                            sram_oe_n <= 1'b0;
                        end
                    end else if (if_req) begin
                        own_data  <= 1'b0;
                        sram_addr <= if_addr[ADDR_W+1:2];
                        sram_be_n <= 4'h0;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (wait_cnt == 4'd0) begin
                        if (own_data) begin
                            data_rdata <= sram_dq_i;
                            data_ack   <= 1'b1;
                        end else begin
                            if_rdata <= sram_dq_i;
                            if_ack   <= 1'b1;
                        end
                        state     <= DONE;
                        wait_cnt  <= WAIT_LD;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= 4'hF;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WR_SETUP: begin
                    state     <= WR_PULSE;
                    wait_cnt  <= WAIT_LD;
                    sram_we_n <= 1'b0;
                end
                WR_PULSE: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= WR_HOLD;
                        wait_cnt  <= WAIT_LD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    // Releasing DQ here leaves DONE as the turnaround cycle before any read.
                    state      <= DONE;
                    wait_cnt   <= WAIT_LD;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_be_n  <= 4'hF;
                    if (own_data) data_ack <= 1'b1;
                    else          if_ack   <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    wait_cnt <= WAIT_LD;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be_n = 4'h0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        stall;
    logic [19:0] sram_addr;
    logic [31:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_i;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    logic        z_if_ack, z_data_ack, z_stall, z_dq_oe, z_ce_n, z_oe_n, z_we_n;
    logic [31:0] z_if_rdata, z_data_rdata, z_dq_o;
    logic [19:0] z_addr;
    logic [3:0]  z_be_n;
    logic        z_data_req = 1'b0;
    logic        z_data_we = 1'b0;
    logic [31:0] z_dq_i = 32'hC0DE_0001;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .data_req(data_req), .data_we(data_we), .data_be_n(data_be_n),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
        .data_rdata(data_rdata), .stall(stall),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'd0), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
        .data_req(z_data_req), .data_we(z_data_we), .data_be_n(4'h0),
        .data_addr(32'h0000_0020), .data_wdata(32'h0F0F_0F0F), .data_ack(z_data_ack),
        .data_rdata(z_data_rdata), .stall(z_stall),
        .sram_addr(z_addr), .sram_dq_o(z_dq_o), .sram_dq_oe(z_dq_oe),
        .sram_dq_i(z_dq_i), .sram_ce_n(z_ce_n), .sram_oe_n(z_oe_n),
        .sram_we_n(z_we_n), .sram_be_n(z_be_n)
    );

    logic [31:0] mem [0:255];
    assign sram_dq_i = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          if_cyc, data_cyc, we_lo, we_first, we_last, oe_lo, stall_hi;
    logic [19:0] addr_seen;
    logic [3:0]  be_seen;
    logic [1:0]  done_bus;

    task automatic run(input bit do_if, input bit do_data);
        bit want_if, want_data, got_addr;
        want_if = do_if; want_data = do_data; got_addr = 0;
        if_cyc = -1; data_cyc = -1; we_lo = 0; we_first = -1; we_last = -1;
        oe_lo = 0; stall_hi = 0; addr_seen = '0; be_seen = 4'hF; done_bus = 2'b11;
        @(posedge clk); #1;
        if_req = do_if; data_req = do_data;
        for (int k = 0; k < 40 && (want_if || want_data); k++) begin
            @(negedge clk);
            check("turnaround", {31'b0, sram_dq_oe & ~sram_oe_n}, 32'd0);
            if (!sram_we_n) begin
                if (we_first < 0) we_first = k;
                we_last = k;
                we_lo++;
            end
            if (!sram_oe_n) oe_lo++;
            if (stall) stall_hi++;
            if (!sram_ce_n && !got_addr) begin
                addr_seen = sram_addr; be_seen = sram_be_n; got_addr = 1;
            end
            if (want_if && if_ack) begin
                if_cyc = k; want_if = 0; if_req = 0;
            end
            if (want_data && data_ack) begin
                data_cyc = k; want_data = 0; data_req = 0;
                done_bus = {sram_dq_oe, sram_oe_n};
            end
        end
        check("ack_timeout", {30'b0, want_if, want_data}, 32'd0);
    endtask

    task automatic z_run(input bit we, output int cyc, output int welo);
        cyc = -1; welo = 0;
        @(posedge clk); #1;
        z_data_req = 1'b1; z_data_we = we;
        for (int k = 0; k < 20 && cyc < 0; k++) begin
            @(negedge clk);
            if (!z_we_n) welo++;
            if (z_data_ack) begin
                cyc = k; z_data_req = 1'b0;
            end
        end
    endtask

    initial begin
        int zc, zw;
        bit seen_pulse;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0100_0000 * i;
        mem[8'h04] = 32'h2402_0005;
        mem[8'h05] = 32'h0BAD_F00D;
        mem[8'h40] = 32'h1122_3344;
        mem[8'h41] = 32'h5566_7788;
        mem[8'h80] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        check("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_be_n", {28'b0, sram_be_n}, 32'hF);
        check("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("rst_addr", {12'b0, sram_addr}, 32'd0);
        check("rst_dq_o", sram_dq_o, 32'd0);
        check("rst_acks", {30'b0, if_ack, data_ack}, 32'd0);
        check("rst_rdata", if_rdata | data_rdata, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        if_addr = 32'h0000_0010;
        run(1, 0);
        check("ifrd_addr", {12'b0, addr_seen}, 32'd4);
        check("ifrd_be", {28'b0, be_seen}, 32'h0);
        check("ifrd_oe_cycles", oe_lo, 32'd2);
        check("ifrd_ack_cycle", if_cyc, 32'd3);
        check("ifrd_rdata", if_rdata, 32'h2402_0005);
        check("ifrd_stall_cycles", stall_hi, 32'd3);

        data_we = 1'b1; data_addr = 32'h0000_0103; data_be_n = 4'b0111; data_wdata = 32'hAAAA_AAAA;
        run(0, 1);
        check("st_addr", {12'b0, addr_seen}, 32'h40);
        check("st_be", {28'b0, be_seen}, 32'h7);
        check("st_we_first", we_first, 32'd2);
        check("st_we_last", we_last, 32'd3);
        check("st_we_cycles", we_lo, 32'd2);
        check("st_oe_cycles", oe_lo, 32'd0);
        check("st_ack_cycle", data_cyc, 32'd5);
        check("st_stall_cycles", stall_hi, 32'd5);
        check("st_done_bus", {30'b0, done_bus}, 32'b01);
        check("st_mem", mem[8'h40], 32'hAA22_3344);

        data_we = 1'b0; data_addr = 32'h0000_0100; data_be_n = 4'b0000;
        run(0, 1);
        check("ld_after_st_cycle", data_cyc, 32'd3);
        check("ld_after_st_rdata", data_rdata, 32'hAA22_3344);

        if_addr = 32'h0000_0014; data_addr = 32'h0000_0200; data_be_n = 4'b1100;
        run(1, 1);
        check("cf_data_ack", data_cyc, 32'd3);
        check("cf_if_ack", if_cyc, 32'd7);
        check("cf_stall_cycles", stall_hi, 32'd7);
        check("cf_first_addr", {12'b0, addr_seen}, 32'h80);
        check("cf_first_be", {28'b0, be_seen}, 32'hC);
        check("cf_data_rdata", data_rdata, 32'hDEAD_BEEF);
        check("cf_if_rdata", if_rdata, 32'h0BAD_F00D);

        data_we = 1'b1; data_addr = 32'h0000_0104; data_be_n = 4'b1111; data_wdata = 32'h0000_0000;
        run(0, 1);
        check("nobe_ack_cycle", data_cyc, 32'd5);
        check("nobe_we_cycles", we_lo, 32'd2);
        check("nobe_mem", mem[8'h41], 32'h5566_7788);

        if_addr = 32'hFFF0_0010;
        run(1, 0);
        check("hiaddr_addr", {12'b0, addr_seen}, 32'h000C_0004);
        check("hiaddr_rdata", if_rdata, 32'h2402_0005);
        check("hold_data_rdata", data_rdata, 32'hDEAD_BEEF);

        z_run(0, zc, zw);
        check("w0_rd_ack_cycle", zc, 32'd2);
        check("w0_rd_rdata", z_data_rdata, 32'hC0DE_0001);
        z_run(1, zc, zw);
        check("w0_wr_ack_cycle", zc, 32'd4);
        check("w0_we_cycles", zw, 32'd1);

        data_we = 1'b1; data_addr = 32'h0000_0108; data_be_n = 4'h0; data_wdata = 32'h1234_5678;
        @(posedge clk); #1 data_req = 1'b1;
        seen_pulse = 0;
        for (int k = 0; k < 10 && !seen_pulse; k++) begin
            @(negedge clk);
            if (!sram_we_n) seen_pulse = 1;
        end
        check("mid_rst_pulse_seen", {31'b0, seen_pulse}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("mid_rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("mid_rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("mid_rst_be_n", {28'b0, sram_be_n}, 32'hF);
        check("mid_rst_addr", {12'b0, sram_addr}, 32'd0);
        check("mid_rst_acks", {30'b0, if_ack, data_ack}, 32'd0);
        check("mid_rst_rdata", if_rdata | data_rdata, 32'd0);
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("post_rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("post_rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("post_rst_stall", {31'b0, stall}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
